// File: rtl/bw_clk_sync_pulse_multi.sv
// rtl/bw_clk_sync_pulse_multi.sv - multi-channel async-input synchronizer with edge/level output,
// saturating per-channel pulse counters and a scan chain over the sync/edge/output flops.
module bw_clk_sync_pulse_multi #(
  parameter int NCH   = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic [NCH-1:0]    async_in,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    mode_lvl,
  input  logic              cnt_clr,
  input  logic              si,
  input  logic              se,
  output logic [NCH-1:0]    sync_out,
  output logic [NCH*CW-1:0] pulse_cnt,
  output logic              so
);

  // Per channel the chain holds: stage0..stage DEPTH-1, edge flop, sync_out flop.
  localparam int SLEN = DEPTH + 2;
  localparam int CLEN = NCH * SLEN;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CLEN-1:0]   chain_q, chain_d;
  logic [NCH*CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]    lvl_q, lvl_d;

  logic [NCH-1:0] s_last, edge_prev, out_prev, out_nxt, inc;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign s_last[g]    = chain_q[g*SLEN + DEPTH - 1];
    assign edge_prev[g] = chain_q[g*SLEN + DEPTH];
    assign out_prev[g]  = chain_q[g*SLEN + DEPTH + 1];
    assign out_nxt[g]   = ch_en[g] & s_last[g] & (mode_lvl[g] | ~edge_prev[g]);
    // lvl_q remembers last cycle's mode so an edge->level switch alone never counts.
    assign inc[g]       = mode_lvl[g] ? (out_nxt[g] & ~out_prev[g] & lvl_q[g]) : out_nxt[g];
    assign sync_out[g]  = out_prev[g];
  end

  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    lvl_d   = mode_lvl;
    if (se) begin
      chain_d = {chain_q[CLEN-2:0], si};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        chain_d[i*SLEN] = async_in[i];
        for (int k = 1; k < DEPTH; k++) begin
          chain_d[i*SLEN + k] = chain_q[i*SLEN + k - 1];
        end
        chain_d[i*SLEN + DEPTH]     = s_last[i];
        chain_d[i*SLEN + DEPTH + 1] = out_nxt[i];
        if (cnt_clr) begin
          cnt_d[i*CW +: CW] = inc[i] ? CNT_ONE : '0;
        end else if (inc[i] && (cnt_q[i*CW +: CW] != CNT_MAX)) begin
          cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign pulse_cnt = cnt_q;
  assign so        = chain_q[CLEN-1];

endmodule
